// File: rtl/thinning_pkg.sv
// Shared constants and helpers for the binary thinning row pass.
package thinning_pkg;

  localparam int THIN_WIDTH = 32;

  // Removal window: a pixel is removable when B is in [B_MIN,B_MAX] and A == A_REQ
  localparam logic [3:0] B_MIN = 4'd2;
  localparam logic [3:0] B_MAX = 4'd6;
  localparam logic [3:0] A_REQ = 4'd1;

  // Population count of an 8-bit neighbourhood vector
  function automatic logic [3:0] count_ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'd0, v[k]};
    return n;
  endfunction

endpackage

// File: rtl/thinning_cell.sv
// One interior pixel of the thinning pass: 8 neighbours + centre -> keep bit.
module thinning_cell
  import thinning_pkg::*;
(
  input  logic c,
  input  logic n,
  input  logic ne,
  input  logic e,
  input  logic se,
  input  logic s,
  input  logic sw,
  input  logic w,
  input  logic nw,
  output logic keep
);

  logic [7:0] ring;   // clockwise from N
  logic [7:0] rise;   // 0->1 steps around the ring, wrap NW->N included
  logic [3:0] b_cnt;
  logic [3:0] a_cnt;
  logic       removable;

  assign ring = {nw, w, sw, s, se, e, ne, n};

  // Mark each position k where ring[k]=0 and its clockwise successor is 1
  always_comb begin
    rise = '0;
    for (int k = 0; k < 8; k++) rise[k] = ~ring[k] & ring[(k + 1) % 8];
  end

  assign b_cnt     = count_ones8(ring);
  assign a_cnt     = count_ones8(rise);
  assign removable = (b_cnt >= B_MIN) & (b_cnt <= B_MAX) & (a_cnt == A_REQ);
  assign keep      = c & ~removable;

endmodule

// File: rtl/thinning_row.sv
// One thinning pass over a WIDTH-pixel row segment, registered output.
// Optional feature macro: THINNING_VALID_EN adds in_valid/out_valid qualifying
// the result update.
module thinning_row
  import thinning_pkg::*;
#(
  parameter int WIDTH = THIN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef THINNING_VALID_EN
  input  logic             in_valid,
  output logic             out_valid,
`endif
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] center,
  input  logic [WIDTH-1:0] bottom,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] nxt;

  // Edge columns lack a full neighbourhood, so they pass straight through
  assign nxt[0]       = center[0];
  assign nxt[WIDTH-1] = center[WIDTH-1];

  // Pixel i sees i+1 as its west and i-1 as its east neighbour
  for (genvar i = 1; i < WIDTH - 1; i++) begin : g_cell
    thinning_cell u_cell (
      .c    (center[i]),
      .n    (top[i]),
      .ne   (top[i-1]),
      .e    (center[i-1]),
      .se   (bottom[i-1]),
      .s    (bottom[i]),
      .sw   (bottom[i+1]),
      .w    (center[i+1]),
      .nw   (top[i+1]),
      .keep (nxt[i])
    );
  end

`ifdef THINNING_VALID_EN
  logic vld_q;

  // Result register, loaded only on qualified edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           result <= '0;
    else if (in_valid) result <= nxt;
  end

  // Valid follows data with the same one-cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= in_valid;
  end

  assign out_valid = vld_q;
`else
  // Result register, loaded every edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) result <= '0;
    else     result <= nxt;
  end
`endif

endmodule

// File: tb/tb_thinning_row.sv
// Self-checking bench for thinning_row: literal vectors plus a randomized run
// compared every cycle against a behavioural model of the thinning rule.
module tb_thinning_row;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] top = '0, center = '0, bottom = '0;
  logic [W-1:0] result;
  logic         in_valid = 1'b1;
`ifdef THINNING_VALID_EN
  logic         out_valid;
`endif

  int tests = 0;
  int fails = 0;

  thinning_row #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef THINNING_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .top      (top),
    .center   (center),
    .bottom   (bottom),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Reference: walk every pixel, gather its neighbours clockwise from N,
  // count ones and 0->1 steps around the closed loop.
  function automatic logic [W-1:0] model(input logic [W-1:0] t, c, b);
    logic [W-1:0] r;
    int nb [8];
    int bc, ac;
    r = c;
    for (int i = 1; i < W - 1; i++) begin
      nb[0] = t[i];   nb[1] = t[i-1]; nb[2] = c[i-1]; nb[3] = b[i-1];
      nb[4] = b[i];   nb[5] = b[i+1]; nb[6] = c[i+1]; nb[7] = t[i+1];
      bc = 0; ac = 0;
      for (int k = 0; k < 8; k++) begin
        bc += nb[k];
        if (nb[k] == 0 && nb[(k + 1) % 8] == 1) ac++;
      end
      if (bc >= 2 && bc <= 6 && ac == 1) r[i] = 1'b0;
    end
    return r;
  endfunction

  // Expected registered state, following the same reset/load rules as the block
  logic [W-1:0] exp_res = '0;
  logic         exp_vld = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_res = '0;
      exp_vld = 1'b0;
    end else begin
      if (in_valid) exp_res = model(top, center, bottom);
      exp_vld = in_valid;
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    tests++;
    if (result !== exp_res) begin
      fails++;
      $display("FAIL cycle_result t=%0t got=%08h exp=%08h", $time, result, exp_res);
    end
`ifdef THINNING_VALID_EN
    tests++;
    if (out_valid !== exp_vld) begin
      fails++;
      $display("FAIL cycle_valid t=%0t got=%0b exp=%0b", $time, out_valid, exp_vld);
    end
`endif
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%08h exp=%08h", name, got, expv);
    end
  endtask

  // Drive one vector after a falling edge, then check one edge later
  task automatic lit(input string name, input logic [W-1:0] t, c, b, input logic [W-1:0] expv);
    @(negedge clk);
    #1;
    top = t; center = c; bottom = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk(name, result, expv);
  endtask

  initial begin
    #2;
    chk("reset_state", result, '0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    lit("vec_00EF00FF", 32'h00EF00FF, 32'h00EF00FF, 32'h00EF00FF, 32'h0046007F);
    lit("vec_mixed",    32'h30EE1CBF, 32'h14AF08ED, 32'h34EF1CFD, 32'h14A608E9);
    lit("all_ones",     '1, '1, '1, 32'hFFFFFFFF);
    lit("all_zero",     '0, '0, '0, 32'h00000000);
    lit("isolated",     32'h0, 32'h00010000, 32'h0, 32'h00010000);
    lit("vert_line",    32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    lit("edge_bits",    '1, 32'h80000001, '1, 32'h80000001);

    // Asynchronous reset between edges while the output is nonzero
    lit("pre_reset", '1, '1, '1, 32'hFFFFFFFF);
    #2 rst = 1'b1;
    #1 chk("async_reset", result, '0);
    @(negedge clk);
    #1;
    top = 32'h0; center = 32'h00010000; bottom = 32'h0;
    rst = 1'b0;
    @(posedge clk);
    #1 chk("post_release", result, 32'h00010000);

`ifdef THINNING_VALID_EN
    // Unqualified edge must hold the previous result
    @(negedge clk);
    #1;
    in_valid = 1'b0; top = '1; center = '1; bottom = '0;
    @(posedge clk);
    #1 chk("valid_hold", result, 32'h00010000);
`endif

    // Randomized run with varying pixel density
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      case ($urandom_range(0, 2))
        0: begin top = $urandom() & $urandom(); center = $urandom() & $urandom(); bottom = $urandom() & $urandom(); end
        1: begin top = $urandom() | $urandom(); center = $urandom() | $urandom(); bottom = $urandom() | $urandom(); end
        default: begin top = $urandom(); center = $urandom(); bottom = $urandom(); end
      endcase
`ifdef THINNING_VALID_EN
      in_valid = ($urandom_range(0, 3) != 0);
`endif
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
